// File: rtl/turfio_cin_rx_if.sv
// AXI4-stream style word channel carrying received CIN command words.
interface turfio_cin_rx_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/turfio_cin_rx.sv
// CIN receive word framer: finds bit and word alignment on the 4-bit-per-ifclk
// deserialized stream by locking to the training word, then emits each
// non-idle, non-training 32-bit word on the stream master.
module turfio_cin_rx #(
  parameter logic [31:0] TRAIN_VALUE  = 32'hA55A6996,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned SEARCH_DWELL = 64,
  parameter logic        INV_CIN      = 1'b0
) (
  input  logic                   ifclk_i,
  input  logic                   rst_i,
  input  logic                   train_i,
  input  logic [3:0]             cin_nibble_i,
  turfio_cin_rx_if.master        m_axis_cin,
  output logic                   locked_o,
  output logic [1:0]             bit_offset_o,
  output logic [2:0]             word_phase_o,
  output logic [15:0]            train_err_o,
  output logic                   overflow_o
);

  localparam logic [3:0] LOCK_CNT   = 4'(LOCK_COUNT);
  localparam logic [7:0] DWELL_LAST = 8'(SEARCH_DWELL - 1);
  localparam logic [7:0] REFILL_MIN = 8'd9;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  nibble_q, prev_q;
  logic [7:0]  hist;
  logic [3:0]  aligned;
  logic [31:0] sr_q;
  logic [2:0]  ctr_q;
  logic [2:0]  phase_q, phase_d;
  logic [1:0]  offset_q, offset_d;
  logic [7:0]  dwell_q, dwell_d;
  logic [3:0]  good_q, good_d, good_inc;
  logic [15:0] err_q, err_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        ovf_q;
  logic        match;
  logic        at_phase;

  // Two consecutive nibbles in time order (earliest bit at index 0).
  assign hist     = {nibble_q, prev_q};
  assign aligned  = hist[offset_q +: 4];
  assign match    = (sr_q == TRAIN_VALUE);
  assign at_phase = (ctr_q == phase_q);
  assign good_inc = good_q + 4'd1;

  // Input capture, word shift register and free-running nibble counter.
  always_ff @(posedge ifclk_i) begin
    if (rst_i) begin
      nibble_q <= '0;
      prev_q   <= '0;
      sr_q     <= '0;
      ctr_q    <= '0;
    end else begin
      nibble_q <= cin_nibble_i ^ {4{INV_CIN}};
      prev_q   <= nibble_q;
      sr_q     <= {aligned, sr_q[31:4]};
      ctr_q    <= ctr_q + 3'd1;
    end
  end

  // Alignment state machine and word output decisions.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    dwell_d  = dwell_q;
    phase_d  = phase_q;
    good_d   = good_q;
    err_d    = err_q;
    tdata_d  = tdata_q;
    tvalid_d = 1'b0;
    unique case (state_q)
      ST_SEARCH: begin
        dwell_d = dwell_q + 8'd1;
        // Early matches would come from a half-refilled shift register.
        if (match && (dwell_q >= REFILL_MIN)) begin
          phase_d = ctr_q;
          good_d  = 4'd1;
          state_d = ST_VERIFY;
        end else if (dwell_q == DWELL_LAST) begin
          offset_d = offset_q + 2'd1;
          dwell_d  = '0;
        end
      end
      ST_VERIFY: begin
        if (at_phase) begin
          if (match) begin
            good_d = good_inc;
            if (good_inc == LOCK_CNT) state_d = ST_LOCKED;
          end else begin
            state_d = ST_SEARCH;
            dwell_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (at_phase) begin
          tdata_d  = sr_q;
          tvalid_d = !train_i && (sr_q != '0);
          if (train_i && !match) begin
            if (err_q != '1) err_d = err_q + 16'd1;
            state_d = ST_SEARCH;
            dwell_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_SEARCH;
        dwell_d = '0;
      end
    endcase
  end

  // State and output registers; overflow is sticky until reset.
  always_ff @(posedge ifclk_i) begin
    if (rst_i) begin
      state_q  <= ST_SEARCH;
      offset_q <= '0;
      dwell_q  <= '0;
      phase_q  <= '0;
      good_q   <= '0;
      err_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      dwell_q  <= dwell_d;
      phase_q  <= phase_d;
      good_q   <= good_d;
      err_q    <= err_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ovf_q    <= ovf_q | (tvalid_q & ~m_axis_cin.tready);
    end
  end

  assign m_axis_cin.tdata  = tdata_q;
  assign m_axis_cin.tvalid = tvalid_q;
  assign locked_o          = (state_q == ST_LOCKED);
  assign bit_offset_o      = offset_q;
  assign word_phase_o      = phase_q;
  assign train_err_o       = err_q;
  assign overflow_o        = ovf_q;

endmodule
